// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file constants and write-request type
//
// Purpose: constants and types common to the register-file write path.
// Ports:   none (package).
package rf_pkg;

  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_ZERO_REG = 0;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose: grants the first asserted request scanning ptr, ptr+1, ... mod N.
//          Holds no state; the owner keeps and advances the pointer.
// Ports:
//   req       in  N      request vector
//   ptr       in  PTR_W  index of the highest-priority requester (< N)
//   en        in  1      when 0, no grant is issued
//   grant     out N      one-hot grant or all-zero
//   grant_idx out PTR_W  encoded index of the granted requester (0 if none)
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx
);

  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        // Integer modulo keeps the wrap correct for non-power-of-two N.
        idx = (int'(ptr) + i) % N;
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = PTR_W'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter for the register-file write port
//
// Purpose: shares the single register-file write port between NUM_REQ
//          writeback sources, stages the winning write in one register and
//          exposes bypass matches so reads can forward the staged write.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   hold                     blocks new grants; the staged write still drains
//   req_valid/addr/data      packed per-requester write requests
//   req_ready                one-hot grant (handshake = valid & ready)
//   write_enable/register/data  registered write to the register file
//   byp_addr1/2, byp_hit1/2  bypass compare against the staged write
//   byp_data                 forwarded data (equals write_data)
module regfile_write_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int DATA_W  = RF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      write_enable,
  output logic [ADDR_W-1:0]         write_register,
  output logic [DATA_W-1:0]         write_data,
  input  logic [ADDR_W-1:0]         byp_addr1,
  output logic                      byp_hit1,
  input  logic [ADDR_W-1:0]         byp_addr2,
  output logic                      byp_hit2,
  output logic [DATA_W-1:0]         byp_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_REG);

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               write_enable_q, write_enable_d;
  logic [ADDR_W-1:0]  write_register_q, write_register_d;
  logic [DATA_W-1:0]  write_data_q, write_data_d;

  logic               grant_en;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               handshake;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  // Grants are suppressed during reset so no requester sees a handshake that
  // the reset edge would then throw away.
  assign grant_en = rst_n & ~hold;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .en        (grant_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  // The arbiter only grants valid requesters, so any grant is a handshake.
  assign handshake = |grant;

  always_comb begin
    sel_addr = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    sel_data = req_data[int'(grant_idx)*DATA_W +: DATA_W];
  end

  always_comb begin
    rr_ptr_d         = rr_ptr_q;
    write_enable_d   = 1'b0;
    write_register_d = write_register_q;
    write_data_d     = write_data_q;
    if (handshake) begin
      write_register_d = sel_addr;
      write_data_d     = sel_data;
      // x0 writes are consumed but never reach the array.
      write_enable_d   = (sel_addr != ZERO_ADDR);
      if (int'(grant_idx) == NUM_REQ - 1) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q         <= '0;
      write_enable_q   <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
    end else begin
      rr_ptr_q         <= rr_ptr_d;
      write_enable_q   <= write_enable_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
    end
  end

  assign write_enable   = write_enable_q;
  assign write_register = write_register_q;
  assign write_data     = write_data_q;

  assign byp_hit1 = write_enable_q & (write_register_q == byp_addr1) & (byp_addr1 != ZERO_ADDR);
  assign byp_hit2 = write_enable_q & (write_register_q == byp_addr2) & (byp_addr2 != ZERO_ADDR);
  assign byp_data = write_data_q;

endmodule
